// File: rtl/register_free_list_pkg.sv
// Shared sizing constants and types for the physical-register free list.
package register_free_list_pkg;
    localparam int PREG_W         = 6;
    localparam int LREG_COUNT     = 32;
    localparam int PREG_COUNT     = 64;
    localparam int DEPTH          = PREG_COUNT - LREG_COUNT;
    localparam int PTR_W          = 6;
    localparam int IDX_W          = 5;
    localparam int INIT_FREE_BASE = 32;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [IDX_W-1:0]  idx_t;

    function automatic logic [1:0] count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction
endpackage

// File: rtl/register_free_list_if.sv
// Rename/commit/free signal bundle of the free list; slave is the free list itself.
interface register_free_list_if;
    import register_free_list_pkg::*;

    logic  iRESTART_VALID;
    logic  iLOCK;
    logic  iALLOC_0_REQ;
    logic  iALLOC_1_REQ;
    preg_t oALLOC_0_REGNAME;
    preg_t oALLOC_1_REGNAME;
    logic  oALLOC_READY;
    logic  iCOMMIT_0_VALID;
    logic  iCOMMIT_1_VALID;
    logic  iFREE_0_VALID;
    preg_t iFREE_0_REGNAME;
    logic  iFREE_1_VALID;
    preg_t iFREE_1_REGNAME;
    ptr_t  oFREE_COUNT;
    logic  oERROR;

    modport slave (
        input  iRESTART_VALID, iLOCK, iALLOC_0_REQ, iALLOC_1_REQ,
        input  iCOMMIT_0_VALID, iCOMMIT_1_VALID,
        input  iFREE_0_VALID, iFREE_0_REGNAME, iFREE_1_VALID, iFREE_1_REGNAME,
        output oALLOC_0_REGNAME, oALLOC_1_REGNAME, oALLOC_READY, oFREE_COUNT, oERROR
    );

    modport master (
        output iRESTART_VALID, iLOCK, iALLOC_0_REQ, iALLOC_1_REQ,
        output iCOMMIT_0_VALID, iCOMMIT_1_VALID,
        output iFREE_0_VALID, iFREE_0_REGNAME, iFREE_1_VALID, iFREE_1_REGNAME,
        input  oALLOC_0_REGNAME, oALLOC_1_REGNAME, oALLOC_READY, oFREE_COUNT, oERROR
    );
endinterface

// File: rtl/register_free_list_ram.sv
// 32x6 name storage: two write ports, two asynchronous read ports, reset to the initial free names.
module register_free_list_ram
    import register_free_list_pkg::*;
(
    input  logic  iCLOCK,
    input  logic  inRESET,
    input  logic  we0_i,
    input  idx_t  waddr0_i,
    input  preg_t wdata0_i,
    input  logic  we1_i,
    input  idx_t  waddr1_i,
    input  preg_t wdata1_i,
    input  idx_t  raddr0_i,
    input  idx_t  raddr1_i,
    output preg_t rdata0_o,
    output preg_t rdata1_o
);
    preg_t mem_q [DEPTH];

    // Storage array; the two write addresses are always distinct (tail, tail+1).
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PREG_W'(INIT_FREE_BASE + i);
            end
        end else begin
            if (we0_i) begin
                mem_q[waddr0_i] <= wdata0_i;
            end
            if (we1_i) begin
                mem_q[waddr1_i] <= wdata1_i;
            end
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];
endmodule

// File: rtl/register_free_list.sv
// Circular physical-register free list with speculative head, committed head and tail pointers.
module register_free_list
    import register_free_list_pkg::*;
(
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    register_free_list_if.slave  fl
);
    ptr_t       head_q, head_d;
    ptr_t       commit_q, commit_d;
    ptr_t       tail_q, tail_d;
    logic       error_q, error_d;

    ptr_t       count_s;
    logic       ready_s;
    logic       alloc_ok_s;
    logic [1:0] n_alloc_s;
    logic [1:0] n_commit_s;
    logic [1:0] n_free_s;
    ptr_t       occupancy_s;
    ptr_t       in_flight_s;
    preg_t      rdata0_s, rdata1_s;

    // Pointer next-state and protocol error detection.
    always_comb begin
        count_s     = tail_q - head_q;
        ready_s     = (count_s >= PTR_W'(2));
        alloc_ok_s  = !fl.iLOCK && !fl.iRESTART_VALID && ready_s;
        n_alloc_s   = alloc_ok_s ? count2(fl.iALLOC_0_REQ, fl.iALLOC_1_REQ) : 2'd0;
        n_commit_s  = count2(fl.iCOMMIT_0_VALID, fl.iCOMMIT_1_VALID);
        n_free_s    = count2(fl.iFREE_0_VALID, fl.iFREE_1_VALID);
        commit_d    = commit_q + PTR_W'(n_commit_s);
        tail_d      = tail_q + PTR_W'(n_free_s);
        if (fl.iRESTART_VALID) begin
            head_d = commit_d;
        end else begin
            head_d = head_q + PTR_W'(n_alloc_s);
        end
        // Both distances are judged after this cycle's commits retire, so a
        // same-cycle commit+free of a full list is legal.
        occupancy_s = tail_d - commit_d;
        in_flight_s = head_d - commit_d;
        error_d     = error_q
                    | (fl.iALLOC_1_REQ & ~fl.iALLOC_0_REQ)
                    | ((n_free_s != 2'd0) && (occupancy_s > PTR_W'(DEPTH)))
                    | (in_flight_s > PTR_W'(DEPTH));
    end

    // Pointer and sticky error registers.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= PTR_W'(DEPTH);
            error_q  <= 1'b0;
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            error_q  <= error_d;
        end
    end

    register_free_list_ram u_ram (
        .iCLOCK   (iCLOCK),
        .inRESET  (inRESET),
        .we0_i    (fl.iFREE_0_VALID | fl.iFREE_1_VALID),
        .waddr0_i (tail_q[IDX_W-1:0]),
        .wdata0_i (fl.iFREE_0_VALID ? fl.iFREE_0_REGNAME : fl.iFREE_1_REGNAME),
        .we1_i    (fl.iFREE_0_VALID & fl.iFREE_1_VALID),
        .waddr1_i (tail_q[IDX_W-1:0] + IDX_W'(1)),
        .wdata1_i (fl.iFREE_1_REGNAME),
        .raddr0_i (head_q[IDX_W-1:0]),
        .raddr1_i (head_q[IDX_W-1:0] + IDX_W'(1)),
        .rdata0_o (rdata0_s),
        .rdata1_o (rdata1_s)
    );

    assign fl.oALLOC_0_REGNAME = rdata0_s;
    assign fl.oALLOC_1_REGNAME = rdata1_s;
    assign fl.oALLOC_READY     = ready_s;
    assign fl.oFREE_COUNT      = count_s;
    assign fl.oERROR           = error_q;
endmodule

// File: tb/tb_register_free_list.sv
// Self-checking bench for register_free_list: vector table, directed corner cases, random vs queue model.
module tb_register_free_list;
    import register_free_list_pkg::*;

    logic iCLOCK = 1'b0;
    logic inRESET = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    register_free_list_if bus ();
    register_free_list dut (.iCLOCK(iCLOCK), .inRESET(inRESET), .fl(bus));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        lock, a0, a1, rs, c0, c1, f0, f1;
        logic [5:0]  n0, n1;
        int          e0, e1, erdy, ecnt;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic lock, input logic a0, input logic a1, input logic rs,
                                input logic c0, input logic c1, input logic f0, input logic [5:0] n0,
                                input logic f1, input logic [5:0] n1,
                                input int e0, input int e1, input int erdy, input int ecnt);
        vec_t v;
        v.lock = lock; v.a0 = a0; v.a1 = a1; v.rs = rs; v.c0 = c0; v.c1 = c1;
        v.f0 = f0; v.n0 = n0; v.f1 = f1; v.n1 = n1;
        v.e0 = e0; v.e1 = e1; v.erdy = erdy; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic idle();
        bus.iRESTART_VALID = 1'b0; bus.iLOCK = 1'b0;
        bus.iALLOC_0_REQ = 1'b0; bus.iALLOC_1_REQ = 1'b0;
        bus.iCOMMIT_0_VALID = 1'b0; bus.iCOMMIT_1_VALID = 1'b0;
        bus.iFREE_0_VALID = 1'b0; bus.iFREE_0_REGNAME = 6'd0;
        bus.iFREE_1_VALID = 1'b0; bus.iFREE_1_REGNAME = 6'd0;
    endtask

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        inRESET = 1'b0;
        repeat (2) @(posedge iCLOCK);
        #1;
        inRESET = 1'b1;
    endtask

    task automatic check_outs(input string tag, input int e0, input int e1,
                              input int erdy, input int ecnt, input int eerr);
        check({tag, " alloc0"}, int'(bus.oALLOC_0_REGNAME), e0);
        check({tag, " alloc1"}, int'(bus.oALLOC_1_REGNAME), e1);
        check({tag, " ready"},  int'(bus.oALLOC_READY), erdy);
        check({tag, " count"},  int'(bus.oFREE_COUNT), ecnt);
        check({tag, " error"},  int'(bus.oERROR), eerr);
    endtask

    // Reference model: the committed free names in order, plus how many of
    // them rename has taken speculatively.
    logic [5:0] fl_m [$];
    int         spec_m;

    initial begin
        // Lock, partial allocs, restart rewinds, and restart+commit+free together.
        tbl[0] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 32, 33, 1, 32);
        tbl[1] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 32, 33, 1, 32);
        tbl[2] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 32, 33, 1, 32);
        tbl[3] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 34, 35, 1, 30);
        tbl[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 35, 36, 1, 29);
        tbl[5] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 32, 33, 1, 32);
        tbl[6] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 34, 35, 1, 30);
        tbl[7] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 34, 35, 1, 30);
        tbl[8] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 33, 34, 1, 31);
        tbl[9] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd12, 1'b0, 6'd0, 34, 35, 1, 31);

        do_reset();
        check_outs("reset", 32, 33, 1, 32, 0);

        for (int i = 0; i < 10; i++) begin
            bus.iLOCK = tbl[i].lock; bus.iALLOC_0_REQ = tbl[i].a0; bus.iALLOC_1_REQ = tbl[i].a1;
            bus.iRESTART_VALID = tbl[i].rs; bus.iCOMMIT_0_VALID = tbl[i].c0;
            bus.iCOMMIT_1_VALID = tbl[i].c1; bus.iFREE_0_VALID = tbl[i].f0;
            bus.iFREE_0_REGNAME = tbl[i].n0; bus.iFREE_1_VALID = tbl[i].f1;
            bus.iFREE_1_REGNAME = tbl[i].n1;
            step();
            check_outs($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].erdy, tbl[i].ecnt, 0);
        end

        // Name 12 freed during the restart comes out after the 30 reclaimed names.
        idle();
        bus.iALLOC_0_REQ = 1'b1; bus.iALLOC_1_REQ = 1'b1;
        repeat (15) step();
        idle();
        check("append12 alloc0", int'(bus.oALLOC_0_REGNAME), 12);
        check("append12 count", int'(bus.oFREE_COUNT), 1);
        check("append12 ready", int'(bus.oALLOC_READY), 0);

        // Full drain: names 32..63 in order, then empty; requests while empty are ignored.
        do_reset();
        bus.iALLOC_0_REQ = 1'b1; bus.iALLOC_1_REQ = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain%0d alloc0", k), int'(bus.oALLOC_0_REGNAME), 32 + 2 * k);
            check($sformatf("drain%0d alloc1", k), int'(bus.oALLOC_1_REGNAME), 33 + 2 * k);
            step();
        end
        check("empty count", int'(bus.oFREE_COUNT), 0);
        check("empty ready", int'(bus.oALLOC_READY), 0);
        repeat (2) step();
        check("empty hold count", int'(bus.oFREE_COUNT), 0);
        idle();
        bus.iCOMMIT_0_VALID = 1'b1; bus.iCOMMIT_1_VALID = 1'b1;
        bus.iFREE_0_VALID = 1'b1; bus.iFREE_0_REGNAME = 6'd5;
        bus.iFREE_1_VALID = 1'b1; bus.iFREE_1_REGNAME = 6'd7;
        step();
        idle();
        check_outs("refill", 5, 7, 1, 2, 0);

        // Errors: lone slot-1 request, sticky, cleared by asynchronous reset.
        do_reset();
        bus.iALLOC_1_REQ = 1'b1;
        step();
        idle();
        check("err alloc1 only", int'(bus.oERROR), 1);
        check("err alloc1 advance", int'(bus.oFREE_COUNT), 31);
        repeat (3) step();
        check("err sticky", int'(bus.oERROR), 1);
        #2 inRESET = 1'b0;
        #1;
        check_outs("async reset", 32, 33, 1, 32, 0);
        @(posedge iCLOCK); #1;
        inRESET = 1'b1;
        bus.iFREE_0_VALID = 1'b1; bus.iFREE_0_REGNAME = 6'd3;
        step();
        idle();
        check("err overfree", int'(bus.oERROR), 1);

        // Randomized legal traffic against the queue model.
        do_reset();
        fl_m = {};
        for (int i = 0; i < DEPTH; i++) fl_m.push_back(6'(INIT_FREE_BASE + i));
        spec_m = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int nc, nf, room, nal;
            logic ready_m;
            logic [5:0] na, nb;
            idle();
            bus.iRESTART_VALID = ($urandom % 16) == 0;
            bus.iLOCK          = ($urandom % 5) == 0;
            bus.iALLOC_0_REQ   = ($urandom % 4) != 0;
            bus.iALLOC_1_REQ   = bus.iALLOC_0_REQ && ($urandom % 2 == 1);
            nc = $urandom_range(0, (spec_m < 2) ? spec_m : 2);
            bus.iCOMMIT_0_VALID = nc >= 1;
            bus.iCOMMIT_1_VALID = nc == 2;
            room = DEPTH - (fl_m.size() - nc);
            nf = $urandom_range(0, (room < 2) ? room : 2);
            na = 6'($urandom % 64);
            nb = 6'($urandom % 64);
            if (nf == 2) begin
                bus.iFREE_0_VALID = 1'b1; bus.iFREE_0_REGNAME = na;
                bus.iFREE_1_VALID = 1'b1; bus.iFREE_1_REGNAME = nb;
            end else if (nf == 1) begin
                if ($urandom % 2 == 1) begin
                    bus.iFREE_0_VALID = 1'b1; bus.iFREE_0_REGNAME = na;
                end else begin
                    bus.iFREE_1_VALID = 1'b1; bus.iFREE_1_REGNAME = na;
                end
            end
            ready_m = (fl_m.size() - spec_m) >= 2;
            nal = (!bus.iLOCK && !bus.iRESTART_VALID && ready_m)
                ? int'(bus.iALLOC_0_REQ) + int'(bus.iALLOC_1_REQ) : 0;
            for (int j = 0; j < nc; j++) void'(fl_m.pop_front());
            spec_m = bus.iRESTART_VALID ? 0 : spec_m - nc + nal;
            if (nf >= 1) fl_m.push_back(na);
            if (nf == 2) fl_m.push_back(nb);
            step();
            check($sformatf("rnd%0d count", cyc), int'(bus.oFREE_COUNT), fl_m.size() - spec_m);
            check($sformatf("rnd%0d ready", cyc), int'(bus.oALLOC_READY),
                  int'((fl_m.size() - spec_m) >= 2));
            check($sformatf("rnd%0d error", cyc), int'(bus.oERROR), 0);
            if ((fl_m.size() - spec_m) >= 2) begin
                check($sformatf("rnd%0d alloc0", cyc), int'(bus.oALLOC_0_REGNAME), int'(fl_m[spec_m]));
                check($sformatf("rnd%0d alloc1", cyc), int'(bus.oALLOC_1_REGNAME), int'(fl_m[spec_m + 1]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
